// File: rtl/alu_logic_pkg.sv
// Shared operation encoding for the bitwise logic unit and the ALU result mux.
package alu_logic_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NOR    = 3'd3,
    OP_NAND   = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } logic_op_e;

endpackage

// File: rtl/logic_slice.sv
// Purely combinational WIDTH-bit bitwise function with all-zeros / all-ones flags.
module logic_slice
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic_op_e        op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             ones
);

  always_comb begin
    s = '0;
    case (op)
      OP_AND:    s = a & b;
      OP_OR:     s = a | b;
      OP_XOR:    s = a ^ b;
      OP_NOR:    s = ~(a | b);
      OP_NAND:   s = ~(a & b);
      OP_XNOR:   s = ~(a ^ b);
      OP_NOT_A:  s = ~a;
      OP_PASS_A: s = a;
      default:   s = a;
    endcase
  end

  // Reductions also hold for WIDTH=1: zero = !s, ones = s.
  assign zero = ~|s;
  assign ones = &s;

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with a valid/ready stream interface and an optional
// single-entry result register.
module logic_unit_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             zero,
  output logic             ones
);

  logic [WIDTH-1:0] slice_s;
  logic             slice_zero;
  logic             slice_ones;

  logic_slice #(.WIDTH(WIDTH)) u_slice (
    .op   (logic_op_e'(op)),
    .a    (A),
    .b    (B),
    .s    (slice_s),
    .zero (slice_zero),
    .ones (slice_ones)
  );

  // Handshake: a beat moves on a side only in a cycle where that side's
  // valid and ready are both 1; a producer holding valid=1 keeps its data
  // stable until it sees ready, and valid never depends on ready.
  if (OUT_REG != 0) begin : g_reg
    logic             valid_q;
    logic [WIDTH-1:0] s_q;
    logic             zero_q;
    logic             ones_q;
    logic             load;

    // The slot can take a new beat when empty or being drained this cycle.
    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        s_q     <= '0;
        zero_q  <= 1'b1;
        ones_q  <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        s_q     <= slice_s;
        zero_q  <= slice_zero;
        ones_q  <= slice_ones;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid = valid_q;
    assign S         = s_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
  end else begin : g_comb
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign S         = slice_s;
    assign zero      = slice_zero;
    assign ones      = slice_ones;
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized checks of logic_unit_pipe: registered 32-bit
// instance against a queue-based reference, plus an 8-bit pass-through instance.
module tb_logic_unit_pipe;
  import alu_logic_pkg::*;

  localparam int W  = 32;
  localparam int CW = 8;

  // Clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [2:0]    op        = '0;
  logic [W-1:0]  A         = '0;
  logic [W-1:0]  B         = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  S;
  logic          zero;
  logic          ones;

  logic          c_in_valid  = 1'b0;
  logic          c_in_ready;
  logic [2:0]    c_op        = '0;
  logic [CW-1:0] c_A         = '0;
  logic [CW-1:0] c_B         = '0;
  logic          c_out_valid;
  logic          c_out_ready = 1'b0;
  logic [CW-1:0] c_S;
  logic          c_zero;
  logic          c_ones;

  logic_unit_pipe #(.WIDTH(W), .OUT_REG(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .zero(zero), .ones(ones)
  );

  logic_unit_pipe #(.WIDTH(CW), .OUT_REG(0)) dut_comb (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .op(c_op), .A(c_A), .B(c_B), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .S(c_S), .zero(c_zero), .ones(c_ones)
  );

  // Scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  bit           clean_after_reset = 1'b0;

  function automatic logic [63:0] ref_op(input int unsigned o, input logic [63:0] a,
                                         input logic [63:0] b);
    case (o)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      3:       return ~(a | b);
      4:       return ~(a & b);
      5:       return ~(a ^ b);
      6:       return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_errors++;
    $error("FAIL %s: observed no acceptance expected acceptance", tag);
  endtask

  // Driver: one clock cycle. Outputs checked at the falling edge, model
  // advanced at the rising edge using the rules of the stream protocol.
  task automatic cycle(input bit rst, input bit iv, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ordy, output bit accepted);
    bit           rdy_exp;
    logic [63:0]  full;
    logic [W-1:0] head;
    reset = rst; in_valid = iv; op = o; A = a; B = b; out_ready = ordy;
    rdy_exp  = (exp_q.size() == 0) || ordy;
    accepted = 1'b0;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", in_ready, rdy_exp);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("S", S, head);
        chk("zero", zero, head == '0);
        chk("ones", ones, head == '1);
      end else if (clean_after_reset) begin
        chk("rst_S", S, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ones", ones, 0);
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      clean_after_reset = 1'b1;
    end else begin
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (iv && rdy_exp) begin
        full = ref_op(o, 64'(a), 64'(b));
        exp_q.push_back(full[W-1:0]);
        clean_after_reset = 1'b0;
        accepted = 1'b1;
      end
    end
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      cycle(1'b0, 1'b1, o, a, b, ordy, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) fail_now("send_timeout");
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    cycle(1'b0, 1'b0, 3'd0, '0, '0, ordy, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit           acc;
    logic [W-1:0] a1, b1, a2, b2, a3, b3, first;
    logic [63:0]  full;

    // Reset state and first-cycle readiness
    cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, acc);
    cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, acc);
    idle(1'b1);

    // NOR, one cycle after acceptance
    cycle(1'b0, 1'b1, 3'd3, 32'h0000_FFFF, 32'h00FF_00FF, 1'b1, acc);
    chk("nor_valid", out_valid, 1);
    chk("nor_S", S, 32'hFF00_0000);
    chk("nor_zero", zero, 0);
    chk("nor_ones", ones, 0);
    idle(1'b1);

    // XOR then XNOR of equal operands
    cycle(1'b0, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, acc);
    chk("xor_S", S, 0);
    chk("xor_zero", zero, 1);
    cycle(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, acc);
    chk("xnor_S", S, 32'hFFFF_FFFF);
    chk("xnor_ones", ones, 1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: three beats, downstream stalled for 4 cycles
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    a3 = $urandom; b3 = $urandom;
    first = a1 & b1;
    cycle(1'b0, 1'b1, 3'd0, a1, b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 3'd1, a2, b2, 1'b0, acc);
      chk("bp_hold_S", S, first);
      chk("bp_in_ready", in_ready, 0);
    end
    send(3'd1, a2, b2, 1'b1);
    send(3'd2, a3, b3, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Full-throughput random stream
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1, acc);
      if (!acc) fail_now("stream_accept");
      chk("stream_valid", out_valid, 1);
    end
    idle(1'b1);
    idle(1'b1);

    // Reset while a result is held under backpressure
    cycle(1'b0, 1'b1, 3'd4, $urandom, $urandom, 1'b0, acc);
    cycle(1'b0, 1'b0, 3'd0, '0, '0, 1'b0, acc);
    cycle(1'b1, 1'b0, 3'd0, '0, '0, 1'b0, acc);
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_S", S, 0);
    chk("rstmid_zero", zero, 1);
    chk("rstmid_ones", ones, 0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Pass-through instance, 8 bits
    c_in_valid = 1'b1; c_op = 3'd6; c_A = 8'h5A; c_B = 8'($urandom); c_out_ready = 1'b0;
    #1;
    chk("comb_not_S", c_S, 8'hA5);
    chk("comb_valid1", c_out_valid, 1);
    chk("comb_ready0", c_in_ready, 0);
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    #1;
    chk("comb_valid0", c_out_valid, 0);
    chk("comb_ready1", c_in_ready, 1);
    for (int i = 0; i < 16; i++) begin
      c_op = 3'(i % 8); c_A = 8'($urandom); c_B = 8'($urandom);
      if (i == 8) c_B = c_A;
      #1;
      full = ref_op(32'(c_op), 64'(c_A), 64'(c_B));
      chk("comb_S", c_S, full[CW-1:0]);
      chk("comb_zero", c_zero, full[CW-1:0] == '0);
      chk("comb_ones", c_ones, full[CW-1:0] == '1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
